// File: rtl/serial_sub_pkg.sv
// ============================================================================
// serial_sub_pkg : shared state type and limits for the serial subtractor
// Rev 1.0
// ============================================================================
`default_nettype none

package serial_sub_pkg;
   typedef enum logic [1:0] {
      SS_IDLE  = 2'b00,
      SS_SHIFT = 2'b01,
      SS_DONE  = 2'b10
   } ss_state_t;

   localparam int SS_MAX_WIDTH = 64;
endpackage

`default_nettype wire

// File: rtl/serial_sub_if.sv
// ============================================================================
// serial_sub_if : start/busy/done request bus; ovf present with SERIAL_SUB_OVF_EN
// Rev 1.0
// ============================================================================
`default_nettype none

interface serial_sub_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf;

   modport master (output start, a, b, bin, input busy, done, diff, bout, ovf);
   modport slave  (input start, a, b, bin, output busy, done, diff, bout, ovf);
`else
   modport master (output start, a, b, bin, input busy, done, diff, bout);
   modport slave  (input start, a, b, bin, output busy, done, diff, bout);
`endif
endinterface

`default_nettype wire

// File: rtl/serial_sub_ctrl_fs_bit.sv
// ============================================================================
// fs_bit : combinational 1-bit full subtractor cell (d = a - b - bin)
// Rev 1.0
// ============================================================================
`default_nettype none

module fs_bit (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bo
);
   assign d  = a ^ b ^ bin;
   assign bo = (~a & b) | (~(a ^ b) & bin);
endmodule

`default_nettype wire

// File: rtl/serial_sub_ctrl.sv
// ============================================================================
// serial_sub_ctrl : WIDTH-cycle LSB-first serial subtractor; macro SERIAL_SUB_OVF_EN adds ovf
// Rev 1.0
// ============================================================================
`default_nettype none

module serial_sub_ctrl
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   serial_sub_if.slave   bus
);
   localparam int CNT_W = $clog2(WIDTH);

   ss_state_t        r_state;
   ss_state_t        w_state_nxt;
   logic             w_load;
   logic             w_last;
   logic [WIDTH-1:0] r_a_sr;
   logic [WIDTH-1:0] r_b_sr;
   logic [WIDTH-1:0] r_part;
   logic             r_brw;
   logic [CNT_W-1:0] r_idx;
   logic [WIDTH-1:0] r_diff;
   logic             r_bout;
   logic             w_d;
   logic             w_bo;

   fs_bit u_fs_bit (
      .a   (r_a_sr[0]),
      .b   (r_b_sr[0]),
      .bin (r_brw),
      .d   (w_d),
      .bo  (w_bo)
   );

   assign w_last = (r_idx == CNT_W'(WIDTH - 1));

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      case (r_state)
         SS_SHIFT: begin
            if (w_last) begin
               w_state_nxt = SS_DONE;
            end
         end
         // IDLE, DONE and the unreachable 2'b11 all behave as IDLE
         default: begin
            if (bus.start) begin
               w_load      = 1'b1;
               w_state_nxt = SS_SHIFT;
            end else begin
               w_state_nxt = SS_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= SS_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_sr <= '0;
         r_b_sr <= '0;
         r_part <= '0;
         r_brw  <= 1'b0;
         r_idx  <= '0;
         r_diff <= '0;
         r_bout <= 1'b0;
      end else if (w_load) begin
         r_a_sr <= bus.a;
         r_b_sr <= bus.b;
         r_brw  <= bus.bin;
         r_idx  <= '0;
      end else if (r_state == SS_SHIFT) begin
         r_a_sr <= r_a_sr >> 1;
         r_b_sr <= r_b_sr >> 1;
         r_part <= {w_d, r_part[WIDTH-1:1]};
         r_brw  <= w_bo;
         r_idx  <= r_idx + 1'b1;
         if (w_last) begin
            r_diff <= {w_d, r_part[WIDTH-1:1]};
            r_bout <= w_bo;
         end
      end
   end

`ifdef SERIAL_SUB_OVF_EN
   logic r_ovf;

   // r_brw at the last bit is the borrow into the MSB
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (r_state == SS_SHIFT && w_last) begin
         r_ovf <= r_brw ^ w_bo;
      end
   end

   assign bus.ovf = r_ovf;
`endif

   assign bus.busy = (r_state == SS_SHIFT);
   assign bus.done = (r_state == SS_DONE);
   assign bus.diff = r_diff;
   assign bus.bout = r_bout;
endmodule

`default_nettype wire

// File: tb/tb_serial_sub_ctrl.sv
// ============================================================================
// tb_serial_sub_ctrl : directed WIDTH=8 checks plus random ops on WIDTH 2/8/33
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_serial_sub_ctrl;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   serial_sub_if #(.WIDTH(2))  bus2();
   serial_sub_if #(.WIDTH(8))  bus8();
   serial_sub_if #(.WIDTH(33)) bus33();

   serial_sub_ctrl #(.WIDTH(2))  u_dut2  (.clk(clk), .rst_n(rst_n), .bus(bus2));
   serial_sub_ctrl #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
   serial_sub_ctrl #(.WIDTH(33)) u_dut33 (.clk(clk), .rst_n(rst_n), .bus(bus33));

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: plain arithmetic on the operands, no knowledge of the bit-serial sequencing
   function automatic void ref_sub(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic bin, output logic [63:0] d, output logic bo,
                                   output logic ov);
      logic [63:0] mask, aa, bb;
      longint      sa, sb, r, lim;
      mask = (64'd1 << w) - 64'd1;
      aa   = a & mask;
      bb   = b & mask;
      d    = (aa - bb - 64'(bin)) & mask;
      bo   = ({1'b0, aa} < ({1'b0, bb} + 65'(bin)));
      sa   = aa[w-1] ? longint'(aa) - longint'(64'd1 << w) : longint'(aa);
      sb   = bb[w-1] ? longint'(bb) - longint'(64'd1 << w) : longint'(bb);
      r    = sa - sb - longint'(bin);
      lim  = longint'(64'd1 << (w - 1));
      ov   = (r < -lim) || (r > lim - 1);
   endfunction

   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin, output int lat);
      @(negedge clk);
      bus8.a = a; bus8.b = b; bus8.bin = bin; bus8.start = 1'b1;
      @(negedge clk);
      bus8.start = 1'b0;
      lat = 0;
      while (!bus8.done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check_val("op8_done_seen", 64'(bus8.done), 64'd1);
   endtask

   initial begin
      int          lat, lat2;
      logic [63:0] ra, rb, ed;
      logic        rbin, ebo, eov;
      logic [2:0]  got;
      logic [63:0] d2, d8, d33;
      logic        bo2, bo8, bo33;
      logic        ov2, ov8, ov33;

      {bus2.start, bus2.a, bus2.b, bus2.bin}     = '0;
      {bus8.start, bus8.a, bus8.b, bus8.bin}     = '0;
      {bus33.start, bus33.a, bus33.b, bus33.bin} = '0;
      {ov2, ov8, ov33} = '0;

      repeat (3) @(negedge clk);
      check_val("rst_busy", 64'(bus8.busy), 64'd0);
      check_val("rst_done", 64'(bus8.done), 64'd0);
      check_val("rst_diff", 64'(bus8.diff), 64'd0);
      check_val("rst_bout", 64'(bus8.bout), 64'd0);
      rst_n = 1'b1;

      op8(8'h5A, 8'h3C, 1'b0, lat);
      check_val("t1_diff", 64'(bus8.diff), 64'h1E);
      check_val("t1_bout", 64'(bus8.bout), 64'd0);
      check_val("t1_latency", 64'(lat), 64'd8);
      @(negedge clk);
      check_val("t1_done_width", 64'(bus8.done), 64'd0);

      op8(8'h00, 8'h01, 1'b0, lat);
      check_val("t2a_diff", 64'(bus8.diff), 64'hFF);
      check_val("t2a_bout", 64'(bus8.bout), 64'd1);
      op8(8'h10, 8'h10, 1'b1, lat);
      check_val("t2b_diff", 64'(bus8.diff), 64'hFF);
      check_val("t2b_bout", 64'(bus8.bout), 64'd1);

      // start pulses during the op with other operands must be ignored
      @(negedge clk);
      bus8.a = 8'h77; bus8.b = 8'h22; bus8.bin = 1'b0; bus8.start = 1'b1;
      @(negedge clk);
      lat = 0;
      while (!bus8.done && lat < 40) begin
         bus8.start = (lat == 3 || lat == 6);
         bus8.a     = 8'($urandom);
         bus8.b     = 8'($urandom);
         @(negedge clk);
         lat++;
      end
      bus8.start = 1'b0;
      check_val("t3_latency", 64'(lat), 64'd8);
      check_val("t3_diff", 64'(bus8.diff), 64'h55);
      check_val("t3_bout", 64'(bus8.bout), 64'd0);

      // start held high through the done cycle gives a back-to-back op
      @(negedge clk);
      bus8.a = 8'h33; bus8.b = 8'h11; bus8.bin = 1'b0; bus8.start = 1'b1;
      @(negedge clk);
      bus8.a = 8'h09; bus8.b = 8'h04;
      lat = 0;
      while (!bus8.done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check_val("t4_first_diff", 64'(bus8.diff), 64'h22);
      check_val("t4_first_lat", 64'(lat), 64'd8);
      @(negedge clk);
      check_val("t4_busy_next", 64'(bus8.busy), 64'd1);
      check_val("t4_done_fell", 64'(bus8.done), 64'd0);
      lat2 = 1;
      while (!bus8.done && lat2 < 40) begin
         @(negedge clk);
         lat2++;
      end
      bus8.start = 1'b0;
      check_val("t4_gap", 64'(lat2), 64'd9);
      check_val("t4_second_diff", 64'(bus8.diff), 64'h05);
      check_val("t4_second_bout", 64'(bus8.bout), 64'd0);
      @(negedge clk);
      check_val("t4_idle_busy", 64'(bus8.busy), 64'd0);

      // async reset mid-op: outputs clear at once and no done follows
      bus8.a = 8'hC3; bus8.b = 8'h21; bus8.bin = 1'b0; bus8.start = 1'b1;
      @(negedge clk);
      bus8.start = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_val("t5_busy", 64'(bus8.busy), 64'd0);
      check_val("t5_done", 64'(bus8.done), 64'd0);
      check_val("t5_diff", 64'(bus8.diff), 64'd0);
      check_val("t5_bout", 64'(bus8.bout), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      lat = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus8.done || bus8.busy) lat++;
      end
      check_val("t5_no_done", 64'(lat), 64'd0);
      op8(8'hC3, 8'h21, 1'b0, lat);
      check_val("t5_after_diff", 64'(bus8.diff), 64'hA2);

`ifdef SERIAL_SUB_OVF_EN
      op8(8'h80, 8'h01, 1'b0, lat);
      check_val("t6a_diff", 64'(bus8.diff), 64'h7F);
      check_val("t6a_ovf", 64'(bus8.ovf), 64'd1);
      op8(8'h7F, 8'hFF, 1'b0, lat);
      check_val("t6b_diff", 64'(bus8.diff), 64'h80);
      check_val("t6b_ovf", 64'(bus8.ovf), 64'd1);
      op8(8'h05, 8'h03, 1'b0, lat);
      check_val("t6c_ovf", 64'(bus8.ovf), 64'd0);
`endif

      for (int n = 0; n < 1000; n++) begin
         ra   = {$urandom, $urandom};
         rb   = {$urandom, $urandom};
         rbin = 1'($urandom);
         @(negedge clk);
         bus2.a  = ra[1:0];  bus2.b  = rb[1:0];  bus2.bin  = rbin; bus2.start  = 1'b1;
         bus8.a  = ra[7:0];  bus8.b  = rb[7:0];  bus8.bin  = rbin; bus8.start  = 1'b1;
         bus33.a = ra[32:0]; bus33.b = rb[32:0]; bus33.bin = rbin; bus33.start = 1'b1;
         @(negedge clk);
         bus2.start = 1'b0; bus8.start = 1'b0; bus33.start = 1'b0;
         got = '0;
         lat = 0;
         while (got != 3'b111 && lat < 40) begin
            if (bus2.done && !got[0]) begin
               got[0] = 1'b1; d2 = 64'(bus2.diff); bo2 = bus2.bout;
`ifdef SERIAL_SUB_OVF_EN
               ov2 = bus2.ovf;
`endif
            end
            if (bus8.done && !got[1]) begin
               got[1] = 1'b1; d8 = 64'(bus8.diff); bo8 = bus8.bout;
`ifdef SERIAL_SUB_OVF_EN
               ov8 = bus8.ovf;
`endif
            end
            if (bus33.done && !got[2]) begin
               got[2] = 1'b1; d33 = 64'(bus33.diff); bo33 = bus33.bout;
`ifdef SERIAL_SUB_OVF_EN
               ov33 = bus33.ovf;
`endif
            end
            @(negedge clk);
            lat++;
         end
         check_val("rnd_done_all", 64'(got), 64'd7);
         ref_sub(2, ra, rb, rbin, ed, ebo, eov);
         check_val("rnd_w2_diff", d2, ed);
         check_val("rnd_w2_bout", 64'(bo2), 64'(ebo));
`ifdef SERIAL_SUB_OVF_EN
         check_val("rnd_w2_ovf", 64'(ov2), 64'(eov));
`endif
         ref_sub(8, ra, rb, rbin, ed, ebo, eov);
         check_val("rnd_w8_diff", d8, ed);
         check_val("rnd_w8_bout", 64'(bo8), 64'(ebo));
`ifdef SERIAL_SUB_OVF_EN
         check_val("rnd_w8_ovf", 64'(ov8), 64'(eov));
`endif
         ref_sub(33, ra, rb, rbin, ed, ebo, eov);
         check_val("rnd_w33_diff", d33, ed);
         check_val("rnd_w33_bout", 64'(bo33), 64'(ebo));
`ifdef SERIAL_SUB_OVF_EN
         check_val("rnd_w33_ovf", 64'(ov33), 64'(eov));
`endif
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

`default_nettype wire
